// File: rtl/specs_chk_pkg.sv
// specs_chk_pkg: shared mode encoding, field widths and delay clamp for the checker bank
package specs_chk_pkg;
  localparam int MODE_W = 2;
  localparam int DLY_W = 4;
  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'd0,
    MODE_ALWAYS  = 2'd1,
    MODE_ON_EDGE = 2'd2,
    MODE_NEXT    = 2'd3
  } mode_e;
  function automatic logic [DLY_W-1:0] clamp_dly(input logic [DLY_W-1:0] d, input int max_dly);
    return d == '0 ? DLY_W'(1) : (int'(d) > max_dly ? DLY_W'(max_dly) : d);
  endfunction
endpackage

// File: rtl/specs_checker_bank_if.sv
// specs_checker_bank_if: channel configuration write bus
interface specs_checker_bank_if #(parameter int NUM_CHK = 16);
  import specs_chk_pkg::*;
  localparam int IDX_W = NUM_CHK > 1 ? $clog2(NUM_CHK) : 1;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_idx;
  mode_e            cfg_mode;
  logic [DLY_W-1:0] cfg_dly;
  modport master (output cfg_we, cfg_idx, cfg_mode, cfg_dly);
  modport slave  (input  cfg_we, cfg_idx, cfg_mode, cfg_dly);
endinterface

// File: rtl/specs_chk_channel.sv
// specs_chk_channel: one property checker with mode, edge history, NEXT pending shift, counter and sticky flag
module specs_chk_channel import specs_chk_pkg::*; #(
  parameter int CNT_W   = 16,
  parameter int MAX_DLY = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             evt,
  input  logic             test_expr,
  input  logic             cfg_we,
  input  mode_e            cfg_mode,
  input  logic [DLY_W-1:0] cfg_dly,
  input  logic             clear,
  output logic             viol,
  output logic             fired,
  output logic             sticky,
  output logic [CNT_W-1:0] cnt
);
  mode_e              mode;
  logic [DLY_W-1:0]   dly;
  logic               prev_evt;
  logic [MAX_DLY-1:0] pend;
  logic [MAX_DLY-1:0] due;
  // pend[k] marks an obligation started k+1 enabled cycles ago
  assign due = pend & (MAX_DLY'(1) << (dly - DLY_W'(1)));
  assign viol = enable && !test_expr && (
    mode == MODE_ALWAYS  ? 1'b1 :
    mode == MODE_ON_EDGE ? evt && !prev_evt :
    mode == MODE_NEXT    ? |due : 1'b0);
  always_ff @(posedge clk) begin
    if (rst) begin
      mode     <= MODE_OFF;
      dly      <= DLY_W'(1);
      prev_evt <= 1'b0;
      pend     <= '0;
      fired    <= 1'b0;
      sticky   <= 1'b0;
      cnt      <= '0;
    end else begin
      fired  <= viol;
      sticky <= viol || (sticky && !clear);
      cnt    <= clear ? CNT_W'(viol) : (viol && cnt != '1 ? cnt + 1'b1 : cnt);
      if (cfg_we) begin
        mode     <= cfg_mode;
        dly      <= clamp_dly(cfg_dly, MAX_DLY);
        prev_evt <= 1'b0;
        pend     <= '0;
      end else if (enable) begin
        prev_evt <= evt;
        pend     <= mode == MODE_NEXT ? (pend << 1) | MAX_DLY'(evt) : '0;
      end
    end
  end
endmodule

// File: rtl/specs_checker_bank.sv
// specs_checker_bank: bank of independent assertion checkers with counters and first-violation capture
module specs_checker_bank import specs_chk_pkg::*; #(
  parameter int NUM_CHK = 16,
  parameter int CNT_W   = 16,
  parameter int MAX_DLY = 7,
  localparam int IDX_W  = NUM_CHK > 1 ? $clog2(NUM_CHK) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [NUM_CHK-1:0] evt,
  input  logic [NUM_CHK-1:0] test_expr,
  specs_checker_bank_if.slave cfg,
  input  logic               clear,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [NUM_CHK-1:0] fired,
  output logic [NUM_CHK-1:0] sticky,
  output logic [CNT_W-1:0]   rd_cnt,
  output logic               first_vld,
  output logic [IDX_W-1:0]   first_idx
);
  logic [NUM_CHK-1:0] viol;
  logic [CNT_W-1:0]   cnt [NUM_CHK];
  logic [IDX_W-1:0]   low;
  for (genvar i = 0; i < NUM_CHK; i++) begin : g_ch
    specs_chk_channel #(.CNT_W(CNT_W), .MAX_DLY(MAX_DLY)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .evt       (evt[i]),
      .test_expr (test_expr[i]),
      .cfg_we    (cfg.cfg_we && cfg.cfg_idx == IDX_W'(i)),
      .cfg_mode  (cfg.cfg_mode),
      .cfg_dly   (cfg.cfg_dly),
      .clear     (clear),
      .viol      (viol[i]),
      .fired     (fired[i]),
      .sticky    (sticky[i]),
      .cnt       (cnt[i])
    );
  end
  always_comb begin
    low = '0;
    for (int k = NUM_CHK - 1; k >= 0; k--) if (viol[k]) low = IDX_W'(k);
  end
  // a violation in the clearing cycle re-arms the capture from that cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt    <= '0;
      first_vld <= 1'b0;
      first_idx <= '0;
    end else begin
      rd_cnt <= {1'b0, rd_idx} < (IDX_W + 1)'(NUM_CHK) ? cnt[rd_idx] : '0;
      if (|viol && (!first_vld || clear)) begin
        first_vld <= 1'b1;
        first_idx <= low;
      end else if (clear) begin
        first_vld <= 1'b0;
        first_idx <= '0;
      end
    end
  end
endmodule

// File: tb/tb_specs_checker_bank.sv
// tb_specs_checker_bank: directed self-checking bench for the checker bank
module tb_specs_checker_bank;
  import specs_chk_pkg::*;
  logic        clk = 1'b0;
  logic        rst, enable, clear;
  logic [15:0] evt, test_expr, fired, sticky;
  logic [3:0]  rd_idx, first_idx, rd_cnt;
  logic        first_vld;
  int          passed = 0, total = 0, n, first;
  specs_checker_bank_if #(.NUM_CHK(16)) cfg_bus ();
  specs_checker_bank #(.NUM_CHK(16), .CNT_W(4), .MAX_DLY(7)) dut (
    .clk(clk), .rst(rst), .enable(enable), .evt(evt), .test_expr(test_expr),
    .cfg(cfg_bus), .clear(clear), .rd_idx(rd_idx), .fired(fired), .sticky(sticky),
    .rd_cnt(rd_cnt), .first_vld(first_vld), .first_idx(first_idx)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic cfg_wr(input logic [3:0] idx, input mode_e m, input logic [3:0] d);
    cfg_bus.cfg_we = 1'b1;
    cfg_bus.cfg_idx = idx;
    cfg_bus.cfg_mode = m;
    cfg_bus.cfg_dly = d;
    tick();
    cfg_bus.cfg_we = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; enable = 1'b1; clear = 1'b0; evt = '0; test_expr = '1; rd_idx = '0;
    cfg_bus.cfg_we = 1'b0; cfg_bus.cfg_idx = '0; cfg_bus.cfg_mode = MODE_OFF; cfg_bus.cfg_dly = 4'd1;
    tick(); tick();
    chk("rst_fired", 32'(fired), 32'h0);
    chk("rst_sticky", 32'(sticky), 32'h0);
    chk("rst_rd_cnt", 32'(rd_cnt), 32'h0);
    chk("rst_first_vld", 32'(first_vld), 32'h0);
    chk("rst_first_idx", 32'(first_idx), 32'h0);
    rst = 1'b0;
    cfg_wr(4'd0, MODE_ALWAYS, 4'd1);
    test_expr[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("always_fire", 32'(fired), 32'h1);
    end
    test_expr[0] = 1'b1;
    tick();
    chk("always_quiet", 32'(fired), 32'h0);
    chk("always_cnt", 32'(rd_cnt), 32'd3);
    chk("always_sticky", 32'(sticky), 32'h1);
    chk("always_first_vld", 32'(first_vld), 32'h1);
    chk("always_first_idx", 32'(first_idx), 32'h0);
    cfg_wr(4'd2, MODE_ON_EDGE, 4'd1);
    evt[2] = 1'b1; test_expr[2] = 1'b0; n = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) chk("edge_first", 32'(fired), 32'h4);
      n += int'(fired[2]);
    end
    evt[2] = 1'b0; test_expr[2] = 1'b1; rd_idx = 4'd2;
    tick();
    chk("edge_fires", 32'(n), 32'd1);
    chk("edge_cnt", 32'(rd_cnt), 32'd1);
    chk("edge_first_keep", 32'(first_idx), 32'h0);
    cfg_wr(4'd3, MODE_NEXT, 4'd2);
    evt[3] = 1'b1;
    tick();
    tick();
    chk("next_c11", 32'(fired), 32'h0);
    evt[3] = 1'b0;
    tick();
    chk("next_c12", 32'(fired), 32'h0);
    test_expr[3] = 1'b0;
    tick();
    chk("next_c13", 32'(fired), 32'h8);
    test_expr[3] = 1'b1;
    tick();
    chk("next_c14", 32'(fired), 32'h0);
    evt[3] = 1'b1;
    tick();
    evt[3] = 1'b0; enable = 1'b0; test_expr[0] = 1'b0;
    tick();
    chk("gap_enable_low", 32'(fired), 32'h0);
    enable = 1'b1; test_expr[0] = 1'b1;
    tick();
    chk("gap_c12", 32'(fired), 32'h0);
    test_expr[3] = 1'b0;
    tick();
    chk("gap_c13", 32'(fired), 32'h8);
    test_expr[3] = 1'b1; rd_idx = 4'd3;
    tick();
    chk("gap_cnt", 32'(rd_cnt), 32'd2);
    cfg_wr(4'd4, MODE_NEXT, 4'd0);
    evt[4] = 1'b1; test_expr[4] = 1'b0;
    tick();
    chk("dly0_event_cycle", 32'(fired), 32'h0);
    evt[4] = 1'b0;
    tick();
    chk("dly0_clamped", 32'(fired), 32'h10);
    test_expr[4] = 1'b1;
    cfg_wr(4'd5, MODE_NEXT, 4'd15);
    evt[5] = 1'b1;
    tick();
    evt[5] = 1'b0; test_expr[5] = 1'b0; n = 0; first = -1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (fired[5]) begin
        n++;
        if (first < 0) first = k;
      end
    end
    test_expr[5] = 1'b1;
    chk("dly15_latency", 32'(first), 32'd7);
    chk("dly15_fires", 32'(n), 32'd1);
    cfg_wr(4'd6, MODE_NEXT, 4'd2);
    evt[6] = 1'b1;
    tick();
    evt[6] = 1'b0; test_expr[6] = 1'b0;
    cfg_wr(4'd6, MODE_NEXT, 4'd2);
    tick();
    chk("cfg_flush", 32'(fired), 32'h0);
    test_expr[6] = 1'b1;
    test_expr[0] = 1'b0; rd_idx = 4'd0;
    for (int k = 0; k < 14; k++) tick();
    test_expr[0] = 1'b1;
    tick(); tick();
    chk("sat_cnt", 32'(rd_cnt), 32'd15);
    test_expr[0] = 1'b0;
    tick();
    chk("sat_fire", 32'(fired), 32'h1);
    test_expr[0] = 1'b1;
    tick(); tick();
    chk("sat_hold", 32'(rd_cnt), 32'd15);
    clear = 1'b1; test_expr[0] = 1'b0;
    tick();
    clear = 1'b0; test_expr[0] = 1'b1;
    chk("clrviol_sticky", 32'(sticky), 32'h1);
    chk("clrviol_first_vld", 32'(first_vld), 32'h1);
    chk("clrviol_first_idx", 32'(first_idx), 32'h0);
    tick();
    chk("clrviol_cnt", 32'(rd_cnt), 32'd1);
    rd_idx = 4'd3;
    tick();
    chk("clr_cnt3", 32'(rd_cnt), 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_first_vld", 32'(first_vld), 32'h0);
    chk("clr_sticky", 32'(sticky), 32'h0);
    evt[4] = 1'b1;
    tick();
    evt[4] = 1'b0; test_expr[4] = 1'b0;
    tick();
    chk("cap_vld", 32'(first_vld), 32'h1);
    chk("cap_idx4", 32'(first_idx), 32'd4);
    test_expr[4] = 1'b1; test_expr[0] = 1'b0;
    tick();
    chk("cap_later_fire", 32'(fired), 32'h1);
    chk("cap_no_overwrite", 32'(first_idx), 32'd4);
    test_expr[0] = 1'b1; clear = 1'b1; evt[4] = 1'b1;
    tick();
    clear = 1'b0; evt[4] = 1'b0; test_expr[4] = 1'b0; test_expr[0] = 1'b0;
    tick();
    chk("cap_same_fired", 32'(fired), 32'h11);
    chk("cap_lowest", 32'(first_idx), 32'd0);
    test_expr = '1;
    evt[3] = 1'b1;
    tick();
    evt[3] = 1'b0; rst = 1'b1; test_expr[3] = 1'b0;
    tick();
    chk("rst_mid_fired", 32'(fired), 32'h0);
    chk("rst_mid_sticky", 32'(sticky), 32'h0);
    chk("rst_mid_rd_cnt", 32'(rd_cnt), 32'h0);
    chk("rst_mid_first_vld", 32'(first_vld), 32'h0);
    chk("rst_mid_first_idx", 32'(first_idx), 32'h0);
    rst = 1'b0; test_expr = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_modes_off", 32'(fired), 32'h0);
    end
    chk("rst_sticky_off", 32'(sticky), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/specs_checker_bank.md
SPECS_CHECKER_BANK -- requirements
Module: specs_checker_bank

Interface
REQ-001 SHALL have parameter NUM_CHK, 16, number of independent checker channels (1..32).
REQ-002 SHALL have parameter CNT_W, 16, width of per-channel fire counters.
REQ-003 SHALL have parameter MAX_DLY, 7, largest NEXT-mode delay in enabled cycles (1..15).
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port enable  input  1  global qualifier; checkers sample only when high.
REQ-007 SHALL have port event  input  NUM_CHK  per-channel sampling/start event.
REQ-008 SHALL have port test_expr  input  NUM_CHK  per-channel property value (1 = holds).
REQ-009 SHALL have port cfg_we  input  1  configuration write strobe.
REQ-010 SHALL have port cfg_idx  input  $clog2(NUM_CHK)  channel being configured.
REQ-011 SHALL have port cfg_mode  input  2  0 OFF, 1 ALWAYS, 2 ON_EDGE, 3 NEXT.
REQ-012 SHALL have port cfg_dly  input  4  NEXT-mode delay, 1..MAX_DLY.
REQ-013 SHALL have port clear  input  1  clears sticky flags, counters, first-fire capture.
REQ-014 SHALL have port rd_idx  input  $clog2(NUM_CHK)  counter readout select.
REQ-015 SHALL have port fired  output  NUM_CHK  one-cycle violation pulse per channel.
REQ-016 SHALL have port sticky  output  NUM_CHK  latched violation flags.
REQ-017 SHALL have port rd_cnt  output  CNT_W  fire count of channel rd_idx.
REQ-018 SHALL have port first_vld  output  1  at least one violation since reset/clear.
REQ-019 SHALL have port first_idx  output  $clog2(NUM_CHK)  lowest-index channel of earliest violating cycle.

Function
REQ-020 SHALL evaluate violations only in cycles with enable=1; enable=0 cycles freeze all channel state.
REQ-021 ALWAYS: SHALL flag violation when test_expr[i]=0.
REQ-022 ON_EDGE: SHALL flag violation when event[i]=1, previous enabled-cycle event[i]=0, and test_expr[i]=0.
REQ-023 NEXT: event[i]=1 SHALL start an obligation; test_expr[i] SHALL be checked exactly cfg_dly enabled cycles later; 0 flags violation.
REQ-024 NEXT SHALL track overlapping obligations via a MAX_DLY-deep per-channel pending shift register; no obligation dropped.
REQ-025 OFF SHALL never flag and SHALL hold pending state cleared.
REQ-026 fired[i] SHALL be registered: high exactly one cycle, the cycle after the violating sample.
REQ-027 sticky[i] SHALL set on violation and hold until clear or rst.
REQ-028 Per-channel counter SHALL increment by 1 per violation and saturate at 2^CNT_W-1.
REQ-029 rd_cnt SHALL be registered, one-cycle latency from rd_idx.
REQ-030 first_idx/first_vld SHALL capture on first violating cycle only; later violations SHALL not overwrite.
REQ-031 clear with simultaneous violation: violation wins — sticky=1, counter=1, first capture taken from that cycle.
REQ-032 cfg_we SHALL update channel cfg_idx next cycle and zero its pending register and edge history; sticky/counter unaffected.
REQ-033 cfg_dly of 0 or >MAX_DLY SHALL be clamped to 1 or MAX_DLY respectively.
REQ-034 cfg_idx >= NUM_CHK SHALL be ignored.

Reset
REQ-035 rst SHALL set all modes OFF, delays 1, and zero fired, sticky, counters, rd_cnt, first_vld, first_idx, pending and edge history.
REQ-036 rst mid-obligation SHALL discard pending NEXT obligations without flagging.

Structure
REQ-037 Mode encoding, mode enum typedef and width constants SHALL live in shared package specs_chk_pkg.
REQ-038 Per-channel logic (mode reg, edge history, pending shift, counter, sticky) SHALL be sub-module specs_chk_channel, instantiated NUM_CHK times.

Verification
REQ-039 Ch0 ALWAYS, test_expr[0]=0 for 3 enabled cycles -> fired[0] pulses 3 cycles starting +1, rd_cnt(0)=3, first_idx=0.
REQ-040 Ch2 ON_EDGE, event held high 5 cycles with test=0 -> exactly one fired[2], count=1.
REQ-041 Ch3 NEXT dly=2, events at cycles 10 and 11, test=0 only at cycle 13 -> single violation, fired[3] at cycle 14.
REQ-042 Ch3 NEXT dly=2, event at 10, enable low cycle 11, test=0 at 13 -> violation fired at 14 (11 not counted).
REQ-043 Counter preloaded to 2^CNT_W-1 by repeated violation -> further violations leave it at max; clear plus same-cycle violation -> count=1.
REQ-044 rst asserted with ch3 obligation pending -> no fired, all outputs zero next cycle, modes OFF.
